// File: rtl/nibble_serial_adder_controller.sv
// WIDTH-bit add/subtract built from one 4-bit look-ahead slice, reused once per nibble.
// The carry between nibbles lives in a register. Operands are taken on a start/ready handshake.
module Look_Ahead_Carry_Generator_4_Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;

  // Each carry is expanded into generate/propagate terms so no carry ripples.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end
endmodule

module nibble_serial_adder_controller #(
  parameter int WIDTH = 16
) (
  input  logic             Clock_In,
  input  logic             Reset_In,
  input  logic             Start_In,
  input  logic             Op_Sub_In,
  input  logic [WIDTH-1:0] Data_A_In,
  input  logic [WIDTH-1:0] Data_B_In,
  input  logic             Carry_In,
  output logic             Ready_Out,
  output logic             Result_Valid_Out,
  input  logic             Result_Ack_In,
  output logic [WIDTH-1:0] Sum_Out,
  output logic             Carry_Out,
  output logic             Overflow_Out
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [3:0]       slice_sum;
  logic             slice_cout;

  Look_Ahead_Carry_Generator_4_Bit u_slice (
    .a   (a_reg[4*cnt +: 4]),
    .b   (b_reg[4*cnt +: 4]),
    .cin (carry),
    .sum (slice_sum),
    .cout(slice_cout)
  );

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state            <= IDLE;
      a_reg            <= '0;
      b_reg            <= '0;
      carry            <= 1'b0;
      cnt              <= '0;
      Sum_Out          <= '0;
      Carry_Out        <= 1'b0;
      Overflow_Out     <= 1'b0;
      Result_Valid_Out <= 1'b0;
      Ready_Out        <= 1'b1;
    end else begin
      case (state)
        IDLE: if (Start_In) begin
          a_reg     <= Data_A_In;
          b_reg     <= Op_Sub_In ? ~Data_B_In : Data_B_In;
          carry     <= Op_Sub_In ? 1'b1 : Carry_In;
          cnt       <= '0;
          Ready_Out <= 1'b0;
          state     <= RUN;
        end
        RUN: begin
          Sum_Out[4*cnt +: 4] <= slice_sum;
          carry               <= slice_cout;
          if (cnt == LAST) begin
            Carry_Out        <= slice_cout;
            // b_reg already holds ~B for subtract, so one rule covers both ops.
            Overflow_Out     <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                (slice_sum[3] != a_reg[WIDTH-1]);
            Result_Valid_Out <= 1'b1;
            state            <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: if (Result_Ack_In) begin
          Result_Valid_Out <= 1'b0;
          Ready_Out        <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_controller.sv
// Directed bench for nibble_serial_adder_controller at WIDTH=16 with hand-computed results.
module tb_nibble_serial_adder_controller;
  logic        clk = 1'b0;
  logic        rst, start, op_sub, cin, ack;
  logic [15:0] da, db;
  logic        ready, valid, cout, ovf;
  logic [15:0] sum;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_controller #(.WIDTH(16)) dut (
    .Clock_In(clk), .Reset_In(rst), .Start_In(start), .Op_Sub_In(op_sub),
    .Data_A_In(da), .Data_B_In(db), .Carry_In(cin), .Ready_Out(ready),
    .Result_Valid_Out(valid), .Result_Ack_In(ack), .Sum_Out(sum),
    .Carry_Out(cout), .Overflow_Out(ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and hold Start across one edge; returns with the accept edge done.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    int n = 0;
    while (!ready && n < 20) begin tick(); n++; end
    chk("ready_before_start", {31'd0, ready}, 32'd1);
    da = a; db = b; cin = c; op_sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    da = $urandom; db = $urandom; cin = $urandom; op_sub = $urandom;
  endtask

  task automatic finish_op(input string tag, input logic [15:0] es, input logic ec,
                           input logic eo, input int hold);
    int n = 1;
    while (!valid && n < 20) begin tick(); n++; end
    chk({tag, "_latency"}, n, 5);
    chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    for (int i = 0; i < hold; i++) begin
      start = i[0]; da = 16'hAAAA; db = 16'h5555;
      tick();
      chk({tag, "_hold"}, {sum, 13'd0, cout, ovf, valid}, {es, 13'd0, ec, eo, 1'b1});
      chk({tag, "_hold_ready"}, {31'd0, ready}, 32'd0);
    end
    start = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({tag, "_ready_after_ack"}, {30'd0, ready, valid}, 32'd2);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; cin = 1'b0; ack = 1'b0; da = '0; db = '0;
    repeat (2) tick();
    chk("reset_state", {sum, 12'd0, cout, ovf, valid, ready}, 32'h0000_0001);
    rst = 1'b0;
    tick();

    start_op(16'h1234, 16'h4321, 1'b0, 1'b0); finish_op("add_5555", 16'h5555, 1'b0, 1'b0, 0);
    start_op(16'h000F, 16'h0000, 1'b1, 1'b0); finish_op("add_cin",  16'h0010, 1'b0, 1'b0, 0);
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0); finish_op("add_wrap", 16'h0000, 1'b1, 1'b0, 0);
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0); finish_op("add_ovf",  16'h8000, 1'b0, 1'b1, 0);
    start_op(16'h8000, 16'h0001, 1'b0, 1'b1); finish_op("sub_ovf",  16'h7FFF, 1'b1, 1'b1, 0);
    start_op(16'h0005, 16'h0007, 1'b1, 1'b1); finish_op("sub_neg",  16'hFFFE, 1'b0, 1'b0, 10);
    // Start in the first idle cycle right after the held result was acknowledged.
    start_op(16'h0100, 16'h0023, 1'b0, 1'b0); finish_op("after_hold", 16'h0123, 1'b0, 1'b0, 0);

    // Abort two nibbles into a run; reset must clear outputs without waiting for an edge.
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk("async_reset", {sum, 12'd0, cout, ovf, valid, ready}, 32'h0000_0001);
    tick();
    rst = 1'b0;
    tick();
    start_op(16'h0001, 16'h0001, 1'b0, 1'b0); finish_op("post_reset", 16'h0002, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder_controller.md
Name: nibble_serial_adder_controller

Overview:
Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit look-ahead carry adder slice (Look_Ahead_Carry_Generator_4_Bit), one nibble per clock, LSB nibble first.
- Carry is registered between nibbles.
- Operands are accepted with a ready/start handshake; the result is held until acknowledged.
- Used wherever a wide adder is needed but area matters more than latency.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
NIBBLES, WIDTH/4, derived local parameter, not overridable; number of RUN cycles.

Ports:
Clock_In  input  1  clock; all state updates on rising edge.
Reset_In  input  1  asynchronous, active-high reset.
Start_In  input  1  operation request; accepted only when Ready_Out=1.
Op_Sub_In  input  1  0 = A+B+Carry_In; 1 = A-B (A + ~B + 1; Carry_In ignored).
Data_A_In  input  WIDTH  operand A, sampled on the accepting edge.
Data_B_In  input  WIDTH  operand B, sampled on the accepting edge.
Carry_In  input  1  carry-in for add, sampled on the accepting edge.
Ready_Out  output  1  high in IDLE only.
Result_Valid_Out  output  1  high in DONE only.
Result_Ack_In  input  1  consumer acknowledge of the result.
Sum_Out  output  WIDTH  result register.
Carry_Out  output  1  carry out of MSB nibble; for subtract, 1 = no borrow.
Overflow_Out  output  1  two's-complement signed overflow.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; Sum_Out=0, Carry_Out=0, Overflow_Out=0, Result_Valid_Out=0, Ready_Out=1.
  - Nibble counter, operand registers and carry register cleared.
  - An operation in progress is aborted with no partial result visible.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On Start_In=1, latch A; latch B, inverted if Op_Sub_In=1.
  - Carry register <= Op_Sub_In ? 1 : Carry_In. Counter <= 0. Go to RUN.
  - Start_In while not in IDLE is ignored, not queued.
- RUN, one nibble per cycle, i = counter:
  - Slice inputs: A_reg[4i+3:4i], B_reg[4i+3:4i], carry register.
  - Sum_Out[4i+3:4i] <= slice sum. Carry register <= slice carry.
  - When i = NIBBLES-1: Carry_Out <= slice carry; Overflow_Out <= (A_reg[WIDTH-1] == B_reg[WIDTH-1]) && (sum MSB != A_reg[WIDTH-1]), using B_reg after inversion. Go to DONE.
  - Otherwise counter <= counter+1.
- DONE:
  - Result_Valid_Out=1; Sum_Out, Carry_Out and Overflow_Out held stable.
  - On Result_Ack_In=1, go to IDLE; Ready_Out=1 on the next cycle.
  - Outputs keep their last values in IDLE until the next RUN overwrites them nibble by nibble.
- Result_Ack_In outside DONE is ignored.
- Latency: Result_Valid_Out rises NIBBLES+1 rising edges after the accepting edge (accept edge, then NIBBLES RUN edges); 5 edges for WIDTH=16.
- Throughput: one operation per NIBBLES+2 cycles minimum, with Ack in the first DONE cycle and Start in the first IDLE cycle.
- Operand inputs may change freely after acceptance; only latched copies are used.
- Arithmetic is modulo 2^WIDTH. Carry propagates between nibbles exclusively via the carry register.

Test Plan:
- WIDTH=16, add 0x1234+0x4321, Carry_In=0 -> Sum_Out=0x5555, Carry_Out=0, Overflow_Out=0; Result_Valid_Out rises exactly 5 edges after accept.
- Add 0x000F+0x0000, Carry_In=1 -> 0x0010, proving carry across a nibble boundary. Add 0xFFFF+0x0001 -> 0x0000, Carry_Out=1, Overflow_Out=0.
- Add 0x7FFF+0x0001 -> 0x8000, Carry_Out=0, Overflow_Out=1. Sub 0x8000-0x0001 -> 0x7FFF, Overflow_Out=1, Carry_Out=1.
- Sub 0x0005-0x0007 with Carry_In=1 (must be ignored) -> 0xFFFE, Carry_Out=0, Overflow_Out=0.
- Hold Result_Ack_In=0 for 10 cycles in DONE, pulsing Start_In -> outputs stable, Start ignored. Assert Ack -> Ready_Out=1 next cycle; a new Start is then accepted.
- Assert Reset_In mid-RUN after 2 nibbles -> all outputs 0 immediately (asynchronous), Ready_Out=1. After release, 0x0001+0x0001 -> 0x0002 correct.
